// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// Pipeline register between the 16-bit ALU and the memory/writeback stage.
// Results from the ALU are held in a two-entry skid buffer (head + skid)
// under a valid/ready handshake. The stage also keeps the architectural
// carry/zero/equal status register and exposes the head entry as a
// forwarding tap. A flush discards everything buffered plus the entry
// offered in the same cycle.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       upstream handshake
//   in_result, in_cout,
//   in_zero, in_equal, in_op  ALU result, status bits and control code
//   in_rd, in_wb_en,
//   in_mem_rd, in_mem_wr,
//   in_store_data             destination and memory-control fields
//   flush                     drop all buffered and incoming entries
//   out_valid / out_ready     downstream handshake
//   out_*                     head entry fields
//   flag_carry/zero/equal     status register
//   fwd_valid/fwd_rd/
//   fwd_result                forwarding tap (head entry with wb_en set)
// ---------------------------------------------------------------------------
// state   | meaning
// --------+---------------------------------------------
// S_EMPTY | no entry buffered, head invalid
// S_ONE   | head holds the only entry
// S_FULL  | head and skid both hold entries, in_ready low
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_SIZE    = 4,
    parameter int RA_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_cout,
    input  logic                  in_zero,
    input  logic                  in_equal,
    input  logic [OP_SIZE-1:0]    in_op,
    input  logic [RA_WIDTH-1:0]   in_rd,
    input  logic                  in_wb_en,
    input  logic                  in_mem_rd,
    input  logic                  in_mem_wr,
    input  logic [DATA_WIDTH-1:0] in_store_data,

    input  logic                  flush,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [DATA_WIDTH-1:0] out_store_data,
    output logic [RA_WIDTH-1:0]   out_rd,
    output logic                  out_wb_en,
    output logic                  out_mem_rd,
    output logic                  out_mem_wr,

    output logic                  flag_carry,
    output logic                  flag_zero,
    output logic                  flag_equal,

    output logic                  fwd_valid,
    output logic [RA_WIDTH-1:0]   fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_result
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [OP_SIZE-1:0] OP_COMP = OP_SIZE'(11);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [RA_WIDTH-1:0]   rd;
        logic                  wb_en;
        logic                  mem_rd;
        logic                  mem_wr;
    } entry_t;

    logic [1:0] state;
    entry_t     head;
    entry_t     skid;
    entry_t     in_entry;
    logic       accept;
    logic       retire;

    always_comb begin
        in_entry            = '0;
        in_entry.result     = in_result;
        in_entry.store_data = in_store_data;
        in_entry.rd         = in_rd;
        in_entry.wb_en      = in_wb_en;
        in_entry.mem_rd     = in_mem_rd;
        in_entry.mem_wr     = in_mem_wr;
    end

    // in_ready comes straight from the state register, so it never
    // depends combinationally on out_ready.
    assign in_ready  = (state != S_FULL);
    assign out_valid = (state != S_EMPTY);

    assign accept = in_valid & in_ready & ~flush;
    assign retire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            // A retire in this cycle has already been taken downstream;
            // everything else, including the offered entry, is dropped.
            state <= S_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        head  <= in_entry;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    case ({accept, retire})
                        2'b10: begin
                            skid  <= in_entry;
                            state <= S_FULL;
                        end
                        2'b01: state <= S_EMPTY;
                        2'b11: head  <= in_entry;
                        default: ;
                    endcase
                end
                S_FULL: begin
                    if (retire) begin
                        head  <= skid;
                        state <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    // Status register follows accepted entries only; a flush does not
    // roll it back, it only blocks the update for the flush-cycle entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
            flag_equal <= 1'b0;
        end else if (accept) begin
            if (in_op == OP_COMP) begin
                flag_equal <= in_equal;
            end else begin
                flag_carry <= in_cout;
                flag_zero  <= in_zero;
            end
        end
    end

    assign out_result     = head.result;
    assign out_store_data = head.store_data;
    assign out_rd         = head.rd;
    assign out_wb_en      = head.wb_en;
    assign out_mem_rd     = head.mem_rd;
    assign out_mem_wr     = head.mem_wr;

    assign fwd_valid  = out_valid & head.wb_en;
    assign fwd_rd     = head.rd;
    assign fwd_result = head.result;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline stage between the 16-bit ALU and the memory/writeback stage of the MIPS datapath. It registers each ALU result with its destination and memory-control fields into a two-entry skid buffer under a valid/ready handshake. It maintains the architectural carry/zero/equal status register and exposes a forwarding tap of the oldest buffered result. Flush support discards speculative results on branch redirect.

## Interface
- DATA_WIDTH, 16, datapath width; must match the ALU
- OP_SIZE, 4, width of the ALU control code
- RA_WIDTH, 4, register-file address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry
- in_result  in  DATA_WIDTH  ALU out_alu
- in_cout, in_zero, in_equal  in  1 each  ALU cout, zero, equal
- in_op  in  OP_SIZE  ALU control code that produced in_result
- in_rd  in  RA_WIDTH  destination register
- in_wb_en, in_mem_rd, in_mem_wr  in  1 each  writeback enable, load, store
- in_store_data  in  DATA_WIDTH  store operand
- flush  in  1  discard all buffered and incoming entries
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts head
- out_result, out_store_data  out  DATA_WIDTH  head fields
- out_rd  out  RA_WIDTH; out_wb_en, out_mem_rd, out_mem_wr  out  1 each  head fields
- flag_carry, flag_zero, flag_equal  out  1 each  status register
- fwd_valid  out  1  head valid and out_wb_en set
- fwd_rd  out  RA_WIDTH; fwd_result  out  DATA_WIDTH  forwarding tap (equal to head)

## Operation
- Storage: head register (drives outputs) and skid register; count is 0, 1 or 2. States: EMPTY, ONE, FULL.
- Accept: in_valid & in_ready & !flush. Retire: out_valid & out_ready.
- EMPTY: accept → entry to head, state ONE.
- ONE: accept only → skid, state FULL. Retire only → EMPTY. Accept and retire together → new entry to head, stay ONE.
- FULL: in_ready low, so no accept. Retire → skid moves to head, state ONE.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush.
- Flush has priority. All entries are cleared and the state is EMPTY next cycle. An incoming entry in the flush cycle is not stored. A retire in the flush cycle counts as completed. Status flags are not rolled back.
- Status update on accept only, ignoring flush-cycle inputs:
  - in_op == 11 (COMP): flag_equal <= in_equal; carry and zero hold.
  - Any other op: flag_carry <= in_cout and flag_zero <= in_zero; equal holds.
- Field widths pass through unchanged; no arithmetic on data.
- Reset mid-operation: immediate asynchronous clear to EMPTY. Buffered entries are lost.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid, fwd_valid, all flags = 0.
  - All data, rd and control outputs = 0.
- in_ready is registered: high iff state != FULL. It does not depend combinationally on out_ready.
- Latency: an entry accepted at edge N appears on the outputs after edge N (out_valid high in cycle N+1) if the stage was EMPTY, or with ONE plus simultaneous retire.
- Throughput: one entry per cycle while out_ready stays high.
- Outputs stay stable while out_valid & !out_ready.
- Flags are visible the cycle after the accepting edge.
- fwd_* equals the head fields combinationally from registers, with no extra delay.
- After flush: out_valid = 0 and in_ready = 1 in the next cycle.

## Test plan
- Reset then stream: out_ready=1; accept results 0x0001, 0x0002, 0x0003 on consecutive cycles → out_result shows 0x0001/0x0002/0x0003 one cycle later each; in_ready stays 1.
- Backpressure: out_ready=0; offer 0xAAAA, 0xBBBB, 0xCCCC → first two accepted, in_ready=0 after the second, 0xCCCC held upstream. Raise out_ready → order AAAA, BBBB, CCCC with no loss.
- Flags: ADD with cout=1, zero=0, then COMP with equal=1 and cout=0 → carry=1, zero=0, equal=1. Then SUB with zero=1, cout=0 → carry=0, zero=1, equal=1.
- Flush in FULL with in_valid=1 (in_op=ADD, in_cout=1) → next cycle out_valid=0, in_ready=1; flush-cycle input not stored; flag_carry unchanged.
- Forwarding: head in_rd=5, wb_en=1, result 0x1234 → fwd_valid=1, fwd_rd=5, fwd_result=0x1234. With wb_en=0 → fwd_valid=0.
- Async reset asserted mid-clock while FULL → all outputs at reset values before the next edge; in_ready=1.
